counter_checker: RTL and testbench
==================================

COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, DUT count width.
REQ-002 SHALL have parameter RST_CYCLES, default 1, cycles the DUT reset is held per reset phase; legal range 1..255.
REQ-003 SHALL have parameter RUN1_CYCLES, default 127, first counting phase length; legal range 1..65535.
REQ-004 SHALL have parameter RUN2_CYCLES, default 255, second counting phase length; legal range 1..65535.
REQ-005 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a check sequence.
REQ-008 SHALL have port dut_count, input, WIDTH, registered count from the counter under test.
REQ-009 SHALL have port dut_reset, output, 1, active-high synchronous reset driven to the counter under test.
REQ-010 SHALL have port busy, output, 1, high while a sequence runs.
REQ-011 SHALL have port done, output, 1, high in DONE state.
REQ-012 SHALL have port pass, output, 1, valid when done: 1 iff error_count==0.
REQ-013 SHALL have port error_count, output, 8, saturating mismatch count.
REQ-014 SHALL have port err_expected, output, WIDTH, expected value at first mismatch.
REQ-015 SHALL have port err_observed, output, WIDTH, dut_count at first mismatch.
REQ-016 SHALL have port err_cycle, output, 16, sequence cycle index of first mismatch.

Function
REQ-017 SHALL implement FSM states IDLE, RST1, RUN1, RST2, RUN2, DONE.
REQ-018 SHALL leave IDLE or DONE for RST1 on a clk edge with start=1; start SHALL be ignored in all other states.
REQ-019 SHALL, on entering RST1 from IDLE or DONE, clear error_count, err_expected, err_observed and err_cycle, and zero the 16-bit cycle index.
REQ-020 SHALL hold RST1 and RST2 for RST_CYCLES cycles, RUN1 for RUN1_CYCLES, RUN2 for RUN2_CYCLES; transitions RST1->RUN1->RST2->RUN2->DONE.
REQ-021 SHALL drive dut_reset=1 combinationally in RST1 and RST2, 0 otherwise.
REQ-022 SHALL keep expected register exp (WIDTH bits): at each edge in a non-IDLE/DONE state, exp<=0 if dut_reset else exp+1 modulo 2^WIDTH (wrap 2^WIDTH-1 -> 0 is not an error).
REQ-023 SHALL compare dut_count against current exp at each edge in RUN1, RST2 and RUN2; no compare in RST1, IDLE or DONE.
REQ-024 SHALL increment error_count on each mismatch, saturating at 255.
REQ-025 SHALL capture err_expected, err_observed, err_cycle only on the first mismatch of a sequence.
REQ-026 SHALL increment the cycle index every edge from RST1 entry through the last RUN2 cycle; first RST1 cycle is index 0; saturating at 65535.
REQ-027 SHALL assert busy in RST1..RUN2; done and pass registered, asserted on DONE entry, held until next start.
REQ-028 SHALL produce done exactly RST_CYCLES*2+RUN1_CYCLES+RUN2_CYCLES cycles after the start edge.

Reset
REQ-029 SHALL, on reset_n=0, immediately enter IDLE and drive busy=0, done=0, pass=0, dut_reset=0, error_count=0, err_*=0, exp=0, regardless of state.
REQ-030 SHALL resume only on a new start after reset_n deasserts; an interrupted sequence is discarded.

Verification
REQ-031 Defaults, ideal behavioural counter on dut_count/dut_reset, start pulse -> done after 384 cycles, pass=1, error_count=0.
REQ-032 Ideal counter with dut_count forced to 0xAA for the RUN1 cycle where exp=10 -> error_count=1, err_expected=10, err_observed=0xAA, err_cycle=11.
REQ-033 RUN2_CYCLES=300, ideal counter -> wrap 255->0 inside RUN2, pass=1, error_count=0.
REQ-034 dut_count tied to 0xFF -> error_count saturates at 255, err_expected=0, err_observed=0xFF, err_cycle=1, pass=0.
REQ-035 reset_n low for 3 cycles in mid-RUN2 -> all outputs at reset values, IDLE; new start -> full sequence, pass=1.
REQ-036 start re-pulsed during RUN1 -> ignored, done still at cycle 384; start in DONE -> results cleared, new sequence runs.

Source files
------------

// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : counter_checker
// Description : Built-in checker for a free-running up-counter. On a start
//               pulse it resets the counter under test, lets it run, resets
//               it again, lets it run a second time, and compares every
//               observed count against an internal expected value.
//               Mismatches are counted (saturating) and the first one is
//               captured with its sequence cycle index.
// Ports       : clk          - single clock, rising edge
//               reset_n      - asynchronous active-low reset
//               start        - one-cycle request to begin a sequence
//               dut_count    - registered count from the counter under test
//               dut_reset    - synchronous reset to the counter under test
//               busy         - high while a sequence is running
//               done         - high once the sequence has finished
//               pass         - valid with done: no mismatches seen
//               error_count  - saturating mismatch count
//               err_expected - expected value at the first mismatch
//               err_observed - dut_count at the first mismatch
//               err_cycle    - sequence cycle index of the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module counter_checker #(
    parameter int WIDTH       = 8,
    parameter int RST_CYCLES  = 1,
    parameter int RUN1_CYCLES = 127,
    parameter int RUN2_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dut_count,
    output logic             dut_reset,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       error_count,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_observed,
    output logic [15:0]      err_cycle
);

    // Phase lengths expressed as the terminal value of the phase counter.
    localparam logic [15:0]      c_rst_last  = 16'(RST_CYCLES - 1);
    localparam logic [15:0]      c_run1_last = 16'(RUN1_CYCLES - 1);
    localparam logic [15:0]      c_run2_last = 16'(RUN2_CYCLES - 1);
    localparam logic [WIDTH-1:0] c_exp_one   = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST1 = 3'd1,
        S_RUN1 = 3'd2,
        S_RST2 = 3'd3,
        S_RUN2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_phase;
    logic [15:0]      r_cycle;
    logic [WIDTH-1:0] r_exp;

    logic             w_start_ok;
    logic             w_busy;
    logic             w_dut_reset;
    logic             w_compare;
    logic             w_phase_last;
    logic             w_mismatch;

    // ------------------------------------------------------------------------
    // Next-state and per-state control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_busy       = 1'b0;
        w_dut_reset  = 1'b0;
        w_compare    = 1'b0;
        w_phase_last = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_start_ok = start;
                if (start) begin
                    w_state_next = S_RST1;
                end
            end
            S_RST1: begin
                w_busy       = 1'b1;
                w_dut_reset  = 1'b1;
                w_phase_last = (r_phase == c_rst_last);
                if (w_phase_last) begin
                    w_state_next = S_RUN1;
                end
            end
            S_RUN1: begin
                w_busy       = 1'b1;
                w_compare    = 1'b1;
                w_phase_last = (r_phase == c_run1_last);
                if (w_phase_last) begin
                    w_state_next = S_RST2;
                end
            end
            S_RST2: begin
                // The counter still shows its last RUN1 value here, so the
                // first reset cycle of the second phase is still checked.
                w_busy       = 1'b1;
                w_dut_reset  = 1'b1;
                w_compare    = 1'b1;
                w_phase_last = (r_phase == c_rst_last);
                if (w_phase_last) begin
                    w_state_next = S_RUN2;
                end
            end
            S_RUN2: begin
                w_busy       = 1'b1;
                w_compare    = 1'b1;
                w_phase_last = (r_phase == c_run2_last);
                if (w_phase_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_mismatch = w_compare && (dut_count != r_exp);
    assign dut_reset  = w_dut_reset;
    assign busy       = w_busy;

    // ------------------------------------------------------------------------
    // State, sequencing counters, expected model and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_phase      <= 16'd0;
            r_cycle      <= 16'd0;
            r_exp        <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            error_count  <= 8'd0;
            err_expected <= '0;
            err_observed <= '0;
            err_cycle    <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_phase      <= 16'd0;
                r_cycle      <= 16'd0;
                done         <= 1'b0;
                pass         <= 1'b0;
                error_count  <= 8'd0;
                err_expected <= '0;
                err_observed <= '0;
                err_cycle    <= 16'd0;
            end else if (w_busy) begin
                r_phase <= w_phase_last ? 16'd0 : r_phase + 16'd1;
                r_exp   <= w_dut_reset ? '0 : r_exp + c_exp_one;
                if (r_cycle != 16'hFFFF) begin
                    r_cycle <= r_cycle + 16'd1;
                end
                if (w_mismatch) begin
                    if (error_count != 8'hFF) begin
                        error_count <= error_count + 8'd1;
                    end
                    // error_count never returns to zero within a sequence,
                    // so zero identifies the first mismatch.
                    if (error_count == 8'd0) begin
                        err_expected <= r_exp;
                        err_observed <= dut_count;
                        err_cycle    <= r_cycle;
                    end
                end
                if (w_state_next == S_DONE) begin
                    done <= 1'b1;
                    // Include a mismatch on the final compare edge.
                    pass <= (error_count == 8'd0) && !w_mismatch;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_checker
// Description : Scoreboard bench for counter_checker. Stimulus pushes the
//               expected sequence result into a queue; a monitor pops and
//               compares on every rising edge of done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_checker;

    typedef struct {
        logic        pass;
        logic [7:0]  errc;
        logic [7:0]  eexp;
        logic [7:0]  eobs;
        logic [15:0] ecyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    int          mode = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          edge_n = 0;
    int          tb_cyc = 0;
    int          t_start1 = 0;
    int          t_start2 = 0;

    logic [7:0]  cnt1 = 8'd0;
    logic [7:0]  cnt2 = 8'd0;
    logic [7:0]  dut_count1;
    logic        dut_reset1, busy1, done1, pass1;
    logic [7:0]  errc1, eexp1, eobs1;
    logic [15:0] ecyc1;
    logic        dut_reset2, busy2, done2, pass2;
    logic [7:0]  errc2, eexp2, eobs2;
    logic [15:0] ecyc2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1;
    exp_t m2;
    logic done1_q = 1'b0;
    logic done2_q = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Ideal behavioural counters under test.
    always @(posedge clk) cnt1 <= dut_reset1 ? 8'd0 : cnt1 + 8'd1;
    always @(posedge clk) cnt2 <= dut_reset2 ? 8'd0 : cnt2 + 8'd1;

    // Edges since the last start on DUT1; equals the DUT's cycle index.
    always @(posedge clk) tb_cyc <= start1 ? 0 : tb_cyc + 1;

    // mode 0: ideal, mode 1: 0xAA at cycle index 11, mode 2: stuck at 0xFF
    assign dut_count1 = (mode == 2) ? 8'hFF :
                        ((mode == 1) && (tb_cyc == 11)) ? 8'hAA : cnt1;

    counter_checker u_dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start1),
        .dut_count   (dut_count1),
        .dut_reset   (dut_reset1),
        .busy        (busy1),
        .done        (done1),
        .pass        (pass1),
        .error_count (errc1),
        .err_expected(eexp1),
        .err_observed(eobs1),
        .err_cycle   (ecyc1)
    );

    counter_checker #(.RUN2_CYCLES(300)) u_dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start2),
        .dut_count   (cnt2),
        .dut_reset   (dut_reset2),
        .busy        (busy2),
        .done        (done2),
        .pass        (pass2),
        .error_count (errc2),
        .err_expected(eexp2),
        .err_observed(eobs2),
        .err_cycle   (ecyc2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [7:0] c, input logic [7:0] ee,
                                input logic [7:0] eo, input logic [15:0] ec, input int l);
        exp_t e;
        e.pass = p; e.errc = c; e.eexp = ee; e.eobs = eo; e.ecyc = ec; e.lat = l;
        return e;
    endfunction

    // Monitors: compare whenever done rises.
    always @(negedge clk) begin
        if (done1 && !done1_q) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                m1 = q1.pop_front();
                chk("dut1_pass",        32'(pass1), 32'(m1.pass));
                chk("dut1_error_count", 32'(errc1), 32'(m1.errc));
                chk("dut1_err_expected",32'(eexp1), 32'(m1.eexp));
                chk("dut1_err_observed",32'(eobs1), 32'(m1.eobs));
                chk("dut1_err_cycle",   32'(ecyc1), 32'(m1.ecyc));
                chk("dut1_latency",     32'(edge_n - t_start1), 32'(m1.lat));
                chk("dut1_busy_done",   32'(busy1), 32'd0);
            end
        end
        done1_q = done1;
    end

    always @(negedge clk) begin
        if (done2 && !done2_q) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_done", 32'd1, 32'd0);
            end else begin
                m2 = q2.pop_front();
                chk("dut2_pass",        32'(pass2), 32'(m2.pass));
                chk("dut2_error_count", 32'(errc2), 32'(m2.errc));
                chk("dut2_err_expected",32'(eexp2), 32'(m2.eexp));
                chk("dut2_err_observed",32'(eobs2), 32'(m2.eobs));
                chk("dut2_err_cycle",   32'(ecyc2), 32'(m2.ecyc));
                chk("dut2_latency",     32'(edge_n - t_start2), 32'(m2.lat));
            end
        end
        done2_q = done2;
    end

    // Pulse start on DUT1; optionally queue an expected result and/or
    // record the start edge for latency measurement.
    task automatic issue1(input bit push_it, input bit rec_t, input exp_t e);
        @(negedge clk);
        if (push_it) q1.push_back(e);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        if (rec_t) t_start1 = edge_n;
    endtask

    task automatic issue2(input exp_t e);
        @(negedge clk);
        q2.push_back(e);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        t_start2 = edge_n;
    endtask

    task automatic drain1(input int limit);
        int k = 0;
        while (q1.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("dut1_drain_timeout", 32'(q1.size()), 32'd0);
        q1.delete();
    endtask

    task automatic drain2(input int limit);
        int k = 0;
        while (q2.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("dut2_drain_timeout", 32'(q2.size()), 32'd0);
        q2.delete();
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, "_busy"},         32'(busy1), 32'd0);
        chk({tag, "_done"},         32'(done1), 32'd0);
        chk({tag, "_pass"},         32'(pass1), 32'd0);
        chk({tag, "_dut_reset"},    32'(dut_reset1), 32'd0);
        chk({tag, "_error_count"},  32'(errc1), 32'd0);
        chk({tag, "_err_expected"}, 32'(eexp1), 32'd0);
        chk({tag, "_err_observed"}, 32'(eobs1), 32'd0);
        chk({tag, "_err_cycle"},    32'(ecyc1), 32'd0);
    endtask

    exp_t e_ok;
    exp_t e_ok2;

    initial begin
        e_ok  = mk(1'b1, 8'd0, 8'd0, 8'd0, 16'd0, 384);
        e_ok2 = mk(1'b1, 8'd0, 8'd0, 8'd0, 16'd0, 429);

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle1("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle1("post_reset");

        // Ideal counter, defaults
        mode = 0;
        issue1(1'b1, 1'b1, e_ok);
        chk("rst1_dut_reset", 32'(dut_reset1), 32'd1);
        chk("rst1_busy",      32'(busy1), 32'd1);
        @(negedge clk);
        chk("run1_dut_reset", 32'(dut_reset1), 32'd0);
        drain1(500);

        // Single injected mismatch where exp=10
        mode = 1;
        issue1(1'b1, 1'b1, mk(1'b0, 8'd1, 8'd10, 8'hAA, 16'd11, 384));
        drain1(500);

        // Stuck-at 0xFF: saturation, first mismatch at index 1
        mode = 2;
        issue1(1'b1, 1'b1, mk(1'b0, 8'd255, 8'd0, 8'hFF, 16'd1, 384));
        drain1(500);
        repeat (5) @(negedge clk);
        chk("done_held",  32'(done1), 32'd1);
        chk("pass_held",  32'(pass1), 32'd0);

        // Start in DONE clears results and runs again
        mode = 0;
        issue1(1'b1, 1'b1, e_ok);
        chk("restart_done",        32'(done1), 32'd0);
        chk("restart_busy",        32'(busy1), 32'd1);
        chk("restart_error_count", 32'(errc1), 32'd0);
        chk("restart_err_observed",32'(eobs1), 32'd0);
        chk("restart_err_cycle",   32'(ecyc1), 32'd0);
        drain1(500);

        // Longer RUN2: count wraps 255->0 without error
        issue2(e_ok2);
        drain2(600);

        // Start re-pulsed during RUN1 is ignored
        issue1(1'b1, 1'b1, e_ok);
        repeat (50) @(negedge clk);
        issue1(1'b0, 1'b0, e_ok);
        drain1(500);

        // Reset mid-RUN2 with errors accumulated, then a fresh sequence
        mode = 2;
        issue1(1'b0, 1'b1, e_ok);
        repeat (200) @(negedge clk);
        chk("pre_abort_errors_nonzero", 32'(errc1 != 8'd0), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_idle1("abort_reset");
        repeat (3) @(negedge clk);
        chk_idle1("abort_reset_held");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle1("abort_no_resume");
        mode = 0;
        issue1(1'b1, 1'b1, e_ok);
        drain1(500);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
